// File: rtl/mod60_time_counter.sv
// rtl/mod60_time_counter.sv - mm:ss up/down timer with prescaled one-second steps
// Fields stay in 0..59; all outputs come straight from registers.
module mod60_time_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic       dir,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running,
  output logic       done,
  output logic       sec_tick,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d, wrap_q, wrap_d;

  function automatic logic [5:0] sat59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sec_q   <= '0;
      min_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      sec_d   = '0;
      min_d   = '0;
      pre_d   = '0;
    end else if (load && state_q != RUN) begin
      state_d = IDLE;
      sec_d   = sat59(load_sec);
      min_d   = sat59(load_min);
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // Counting down from 00:00 has nothing to do: finish immediately.
            if (dir && sec_q == '0 && min_q == '0) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              pre_d   = '0;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (!dir) begin
              if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                  min_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  min_d = min_q + 6'd1;
                end
              end else begin
                sec_d = sec_q + 6'd1;
              end
            end else begin
              if (sec_q != '0) begin
                sec_d = sec_q - 6'd1;
              end else begin
                sec_d = 6'd59;
                min_d = (min_q == '0) ? 6'd59 : min_q - 6'd1;
              end
              if (sec_q == 6'd1 && min_q == '0) state_d = DONE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sec      = sec_q;
    min      = min_q;
    running  = (state_q == RUN);
    done     = (state_q == DONE);
    sec_tick = tick_q;
    wrap     = wrap_q;
  end

endmodule

// File: tb/tb_mod60_time_counter.sv
// tb/tb_mod60_time_counter.sv - directed plus randomized checks against a total-seconds model
module tb_mod60_time_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n, start, stop, clear, load, dir;
  logic [5:0] load_sec, load_min, sec, min;
  logic running, done, sec_tick, wrap;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference: time as total seconds mod 3600; st 0=idle 1=run 2=pause 3=done
  int m_t, m_st, m_pre, m_tick, m_wrap;

  mod60_time_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_sec(load_sec), .load_min(load_min), .dir(dir),
    .sec(sec), .min(min), .running(running), .done(done),
    .sec_tick(sec_tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_t = 0; m_st = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
      return;
    end
    m_tick = 0;
    m_wrap = 0;
    if (clear) begin
      m_t = 0; m_pre = 0; m_st = 0;
    end else if (load && m_st != 1) begin
      m_t = sat(int'(load_min)) * 60 + sat(int'(load_sec));
      m_pre = 0; m_st = 0;
    end else if (m_st == 0) begin
      if (start) begin
        if (dir && m_t == 0) m_st = 3;
        else begin m_st = 1; m_pre = 0; end
      end
    end else if (m_st == 1) begin
      if (stop) m_st = 2;
      else if (m_pre == TD - 1) begin
        m_pre = 0;
        m_tick = 1;
        if (!dir) begin
          if (m_t == 3599) m_wrap = 1;
          m_t = (m_t + 1) % 3600;
        end else begin
          m_t = (m_t + 3599) % 3600;
          if (m_t == 0) m_st = 3;
        end
      end else m_pre++;
    end else if (m_st == 2) begin
      if (start) m_st = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("sec", sec, m_t % 60);
    check("min", min, m_t / 60);
    check("running", running, int'(m_st == 1));
    check("done", done, int'(m_st == 3));
    check("sec_tick", sec_tick, m_tick);
    check("wrap", wrap, m_wrap);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start(); start = 1; cycle(); start = 0; endtask
  task automatic pulse_stop();  stop = 1;  cycle(); stop = 0;  endtask
  task automatic pulse_clear(); clear = 1; cycle(); clear = 0; endtask
  task automatic do_load(input int mm, input int ss);
    load_min = 6'(mm); load_sec = 6'(ss); load = 1; cycle(); load = 0;
  endtask

  int wraps;

  initial begin
    rst_n = 0; start = 0; stop = 0; clear = 0; load = 0; dir = 0;
    load_sec = 0; load_min = 0;
    run(2);
    rst_n = 1;

    // reset mid-run
    pulse_start();
    run(9);
    rst_n = 0;
    run(2);
    check("rst_sec", sec, 0);
    check("rst_run", running, 0);
    rst_n = 1;
    run(6);
    check("idle_static", sec, 0);

    // up count
    pulse_clear();
    dir = 0;
    pulse_start();
    run(4);
    check("up_first_sec", sec, 1);
    check("up_first_tick", sec_tick, 1);
    run(236);
    check("up_min", min, 1);
    check("up_sec", sec, 0);

    // wrap
    pulse_clear();
    do_load(59, 58);
    pulse_start();
    wraps = 0;
    for (int i = 0; i < 8; i++) begin cycle(); wraps += int'(wrap); end
    check("wrap_sec", sec, 0);
    check("wrap_min", min, 0);
    check("wrap_pulse", wrap, 1);
    run(4);
    check("wrap_once", wraps + int'(wrap), 1);
    check("after_wrap", sec, 1);

    // countdown
    pulse_clear();
    do_load(1, 0);
    dir = 1;
    pulse_start();
    run(4);
    check("down_sec", sec, 59);
    check("down_min", min, 0);
    run(236);
    check("down_done", done, 1);
    check("down_run", running, 0);
    pulse_start();
    run(8);
    check("done_sticky", done, 1);

    // pause / resume
    pulse_clear();
    dir = 0;
    pulse_start();
    run(2);
    pulse_stop();
    run(10);
    check("pause_sec", sec, 0);
    pulse_start();
    cycle();
    check("resume_early", sec, 0);
    cycle();
    check("resume_sec", sec, 1);
    check("resume_tick", sec_tick, 1);

    // edge commands
    pulse_start(); run(5);
    clear = 1; load_min = 12; load_sec = 34; load = 1; cycle(); clear = 0; load = 0;
    check("clr_over_load", sec, 0);
    do_load(63, 63);
    check("sat_min", min, 59);
    check("sat_sec", sec, 59);
    pulse_start();
    do_load(10, 10);
    check("load_in_run", min, 59);
    pulse_clear();
    dir = 1;
    pulse_start();
    check("zero_down_done", done, 1);
    check("zero_down_tick", sec_tick, 0);

    // randomized commands
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      clear    = ($urandom_range(0, 79) == 0);
      load     = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      load_sec = 6'($urandom_range(0, 63));
      load_min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) load_min = 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
